// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall, jump flush and ID-stage forwarding control
// with a private MEM/WB shadow of write-back destinations.
`default_nettype none

module pipe_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDuseRs,
    input  logic             IDuseRt,
    input  logic             EXwreg,
    input  logic             EXm2reg,
    input  logic [4:0]       EXwn,
    input  logic [1:0]       EXjumpType,
    input  logic             EXbranchTaken,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       IDfwdA,
    output logic [1:0]       IDfwdB,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_next;
    logic             mem_wreg, mem_m2reg, wb_wreg;
    logic [4:0]       mem_wn, wb_wn;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
    logic load_use, jump_kill;

    assign ex_hit_rs  = EXwreg   && (EXwn   == IDrs) && (IDrs != 5'd0);
    assign ex_hit_rt  = EXwreg   && (EXwn   == IDrt) && (IDrt != 5'd0);
    assign mem_hit_rs = mem_wreg && (mem_wn == IDrs) && (IDrs != 5'd0);
    assign mem_hit_rt = mem_wreg && (mem_wn == IDrt) && (IDrt != 5'd0);
    assign wb_hit_rs  = wb_wreg  && (wb_wn  == IDrs) && (IDrs != 5'd0);
    assign wb_hit_rt  = wb_wreg  && (wb_wn  == IDrt) && (IDrt != 5'd0);

    assign load_use  = EXm2reg && ((IDuseRs && ex_hit_rs) || (IDuseRt && ex_hit_rt));
    assign jump_kill = ((EXjumpType == 2'b01) && EXbranchTaken) || EXjumpType[1];

    // WB producers are covered by the register file's write-before-read.
    function automatic logic [1:0] fwd_sel(input logic use_r, input logic ex_hit,
                                           input logic ex_load, input logic mem_hit,
                                           input logic mem_load, input logic wb_hit);
        if (!use_r)                 return 2'b00;
        else if (ex_hit && !ex_load) return 2'b01;
        else if (mem_hit)            return mem_load ? 2'b11 : 2'b10;
        else if (wb_hit)             return 2'b00;
        else                         return 2'b00;
    endfunction

    always_comb begin
        state_next = RUN;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        IDfwdA     = 2'b00;
        IDfwdB     = 2'b00;
        if (clrn) begin
            IDfwdA = fwd_sel(IDuseRs, ex_hit_rs, EXm2reg, mem_hit_rs, mem_m2reg, wb_hit_rs);
            IDfwdB = fwd_sel(IDuseRt, ex_hit_rt, EXm2reg, mem_hit_rt, mem_m2reg, wb_hit_rt);
            if (jump_kill) begin
                flush      = 1'b1;
                bubble     = 1'b1;
                state_next = FLUSH;
            end else if (load_use) begin
                stall      = 1'b1;
                bubble     = 1'b1;
                state_next = LDSTALL;
            end
        end
    end

    // The jump in EX keeps its own write (jal); only younger instructions die.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= RUN;
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
            mem_wn    <= 5'd0;
            wb_wreg   <= 1'b0;
            wb_wn     <= 5'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            mem_wreg  <= EXwreg;
            mem_m2reg <= EXm2reg;
            mem_wn    <= EXwn;
            wb_wreg   <= mem_wreg;
            wb_wn     <= mem_wn;
            if ((state == LDSTALL) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if ((state == FLUSH) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    // Visible counts include the event class held in state this cycle.
    assign stallCount = ((state == LDSTALL) && (stall_cnt != '1)) ? stall_cnt + CNT_ONE : stall_cnt;
    assign flushCount = ((state == FLUSH)   && (flush_cnt != '1)) ? flush_cnt + CNT_ONE : flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed and random checks against a reference model.
`default_nettype none

module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       clrn;
    logic [4:0] IDrs, IDrt, EXwn;
    logic       IDuseRs, IDuseRt, EXwreg, EXm2reg, EXbranchTaken;
    logic [1:0] EXjumpType;

    logic        stall, bubble, flush, stall2, bubble2, flush2;
    logic [1:0]  IDfwdA, IDfwdB, fwdA2, fwdB2;
    logic [15:0] stallCount, flushCount;
    logic [1:0]  stallCount2, flushCount2;

    int total = 0;
    int passed = 0;
    int fails = 0;

    typedef struct {
        bit       wreg;
        bit       m2reg;
        bit [4:0] wn;
    } rec_t;

    rec_t prev_ex;          // instruction that was in EX one cycle ago
    int   n_stall, n_flush; // event counts since reset

    always #5 clk = ~clk;

    pipe_hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .IDrs(IDrs), .IDrt(IDrt),
        .IDuseRs(IDuseRs), .IDuseRt(IDuseRt), .EXwreg(EXwreg), .EXm2reg(EXm2reg),
        .EXwn(EXwn), .EXjumpType(EXjumpType), .EXbranchTaken(EXbranchTaken),
        .stall(stall), .bubble(bubble), .flush(flush), .IDfwdA(IDfwdA), .IDfwdB(IDfwdB),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    pipe_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .clrn(clrn), .IDrs(IDrs), .IDrt(IDrt),
        .IDuseRs(IDuseRs), .IDuseRt(IDuseRt), .EXwreg(EXwreg), .EXm2reg(EXm2reg),
        .EXwn(EXwn), .EXjumpType(EXjumpType), .EXbranchTaken(EXbranchTaken),
        .stall(stall2), .bubble(bubble2), .flush(flush2), .IDfwdA(fwdA2), .IDfwdB(fwdB2),
        .stallCount(stallCount2), .flushCount(flushCount2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Youngest producer of r wins; a load still in EX cannot supply data yet.
    function automatic logic [1:0] exp_fwd(input bit use_r, input bit [4:0] r);
        if (!use_r || r == 0) return 2'b00;
        if (EXwreg && EXwn == r && !EXm2reg) return 2'b01;
        if (prev_ex.wreg && prev_ex.wn == r) return prev_ex.m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        bit         kill, lu;
        logic [1:0] ea, eb;
        #4;
        kill = (EXjumpType == 2'b01 && EXbranchTaken) || EXjumpType >= 2'b10;
        lu   = EXm2reg && EXwreg &&
               ((IDuseRs && IDrs != 0 && EXwn == IDrs) || (IDuseRt && IDrt != 0 && EXwn == IDrt));
        ea   = exp_fwd(IDuseRs, IDrs);
        eb   = exp_fwd(IDuseRt, IDrt);
        if (!clrn) begin
            kill = 0; lu = 0; ea = 0; eb = 0;
        end
        chk("stall",  {31'd0, stall},  {31'd0, !kill && lu});
        chk("bubble", {31'd0, bubble}, {31'd0, kill || lu});
        chk("flush",  {31'd0, flush},  {31'd0, kill});
        chk("fwdA",   {30'd0, IDfwdA}, {30'd0, ea});
        chk("fwdB",   {30'd0, IDfwdB}, {30'd0, eb});
        chk("stallCount",  {16'd0, stallCount},  sat(n_stall, 16));
        chk("flushCount",  {16'd0, flushCount},  sat(n_flush, 16));
        chk("stallCount2", {30'd0, stallCount2}, sat(n_stall, 2));
        chk("flushCount2", {30'd0, flushCount2}, sat(n_flush, 2));
        @(posedge clk);
        if (!clrn) begin
            prev_ex = '{0, 0, 5'd0};
            n_stall = 0;
            n_flush = 0;
        end else begin
            prev_ex = '{EXwreg, EXm2reg, EXwn};
            if (kill) n_flush++;
            else if (lu) n_stall++;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit [4:0] rs, input bit urs, input bit [4:0] rt, input bit urt);
        IDrs = rs; IDuseRs = urs; IDrt = rt; IDuseRt = urt;
    endtask

    task automatic set_ex(input bit w, input bit m, input bit [4:0] wn,
                          input bit [1:0] jt, input bit bt);
        EXwreg = w; EXm2reg = m; EXwn = wn; EXjumpType = jt; EXbranchTaken = bt;
    endtask

    initial begin
        prev_ex = '{0, 0, 5'd0};
        n_stall = 0;
        n_flush = 0;
        clrn = 1'b0;
        set_id(0, 0, 0, 0);
        set_ex(0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            set_id(5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
            set_ex(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
            step();
        end
        clrn = 1'b1;
        set_id(3, 1, 4, 1);
        set_ex(0, 0, 0, 0, 0);
        step();
        step();

        // EX forwarding then MEM forwarding
        set_id(5, 1, 0, 0);
        set_ex(1, 0, 5, 0, 0);
        step();
        chk("ex_fwd_direct", {30'd0, IDfwdA}, 32'd1);
        set_ex(0, 0, 0, 0, 0);
        step();

        // Load-use: one stall, then load data from MEM
        set_id(0, 0, 7, 1);
        set_ex(1, 1, 7, 0, 0);
        step();
        set_ex(0, 0, 0, 0, 0);
        step();
        step();

        // $zero guard
        set_id(0, 1, 0, 0);
        set_ex(1, 1, 0, 0, 0);
        step();

        // Jump priority over load-use, then untaken branch
        set_id(9, 1, 0, 0);
        set_ex(1, 1, 9, 2'b10, 0);
        step();
        set_id(0, 0, 0, 0);
        set_ex(0, 0, 0, 2'b01, 0);
        step();
        set_ex(0, 0, 0, 0, 0);
        step();

        // Saturation: five jumps after a fresh reset
        clrn = 1'b0;
        step();
        clrn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ex(0, 0, 0, (i % 2 == 0) ? 2'b11 : 2'b01, 1);
            step();
        end
        set_ex(0, 0, 0, 0, 0);
        step();
        chk("sat_direct", {30'd0, flushCount2}, 32'd3);

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            clrn = ($urandom_range(0, 24) != 0);
            set_id(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
            set_ex(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 1'($urandom));
            if (EXjumpType != 2'b00) EXwreg = 1'b0;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
